// File: rtl/cache_line_fill_if.sv
// Signal bundle for cache_line_fill: requester, data-RAM and memory-burst ports.
// Handshake: req_do is held with req_address until the one-cycle req_done pulse;
// ram_q answers one cycle after ram_read_do; mem_read_done marks one beat per cycle while mem_read_do is high.
interface cache_line_fill_if;
    logic         req_do;
    logic [31:0]  req_address;
    logic         req_done;
    logic [127:0] req_data;
    logic         invalidate_all;

    logic [31:0]  ram_address;
    logic         ram_read_do;
    logic [147:0] ram_q;
    logic         ram_write_do;
    logic [127:0] ram_data;

    logic         mem_read_do;
    logic [31:0]  mem_address;
    logic         mem_read_done;
    logic [31:0]  mem_read_data;

    modport slave (
        input  req_do, req_address, invalidate_all, ram_q, mem_read_done, mem_read_data,
        output req_done, req_data, ram_address, ram_read_do, ram_write_do, ram_data,
               mem_read_do, mem_address
    );

    modport master (
        output req_do, req_address, invalidate_all, ram_q, mem_read_done, mem_read_data,
        input  req_done, req_data, ram_address, ram_read_do, ram_write_do, ram_data,
               mem_read_do, mem_address
    );
endinterface

// File: rtl/cache_line_fill.sv
// Direct-mapped 256-set cache controller with 128-bit lines filled by a 4-beat memory burst.
// Optional macro CACHE_CRITICAL_WORD_FIRST_EN starts the burst at the requested word.
module cache_line_fill (
    input  logic                    clk,
    input  logic                    rst,
    cache_line_fill_if.slave        bus,
    output logic [1:0]              o_dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_FILL   = 2'd2,
        S_WRITE  = 2'd3
    } state_t;

    state_t       r_state;
    logic [31:0]  r_address;
    logic [255:0] r_valid;
    logic [1:0]   r_beat;
    logic [1:0]   r_start_word;
    logic [127:0] r_line;
    logic [31:0]  r_mem_address;
    logic         r_mem_read_do;

    logic         w_accept;
    logic         w_hit;
    logic [7:0]   w_index;
    logic [1:0]   w_req_start_word;
    logic [31:0]  w_req_mem_address;
    logic [1:0]   w_beat_word;

    assign w_index  = r_address[11:4];
    // Gated by rst so the read strobe stays low while reset is held.
    assign w_accept = (r_state == S_IDLE) && bus.req_do && !rst;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    assign w_req_start_word  = bus.req_address[3:2];
    assign w_req_mem_address = {bus.req_address[31:2], 2'b00};
`else
    assign w_req_start_word  = 2'b00;
    assign w_req_mem_address = {bus.req_address[31:4], 4'b0000};
`endif

    assign w_hit = (r_state == S_LOOKUP) && r_valid[w_index] &&
                   (bus.ram_q[147:128] == r_address[31:12]) && !bus.invalidate_all;
    assign w_beat_word = r_start_word + r_beat;

    assign bus.ram_read_do  = w_accept;
    assign bus.ram_write_do = (r_state == S_WRITE);
    assign bus.ram_address  = (r_state == S_IDLE) ? bus.req_address : r_address;
    assign bus.ram_data     = r_line;
    assign bus.req_done     = w_hit || (r_state == S_WRITE);
    assign bus.req_data     = (r_state == S_LOOKUP) ? bus.ram_q[127:0] : r_line;
    assign bus.mem_read_do  = r_mem_read_do;
    assign bus.mem_address  = r_mem_address;
    assign o_dbg_state      = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_address     <= '0;
            r_valid       <= '0;
            r_beat        <= '0;
            r_start_word  <= '0;
            r_line        <= '0;
            r_mem_address <= '0;
            r_mem_read_do <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_do) begin
                        r_address     <= bus.req_address;
                        r_start_word  <= w_req_start_word;
                        r_mem_address <= w_req_mem_address;
                        r_state       <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_beat        <= 2'd0;
                        r_mem_read_do <= 1'b1;
                        r_state       <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (bus.mem_read_done) begin
                        r_line[{w_beat_word, 5'd0} +: 32] <= bus.mem_read_data;
                        r_beat <= r_beat + 2'd1;
                        if (r_beat == 2'd3) begin
                            r_mem_read_do <= 1'b0;
                            r_state       <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    r_valid[w_index] <= 1'b1;
                    r_state          <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            // Placed last so a coincident invalidate overrides the WRITE valid set.
            if (bus.invalidate_all) begin
                r_valid <= '0;
            end
        end
    end
endmodule

// File: tb/tb_cache_line_fill.sv
// Self-checking bench for cache_line_fill: directed vector table, hand-written
// reset/invalidate sequences, and randomized requests against a cache reference model.
`timescale 1ns/1ps
module tb_cache_line_fill;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    cache_line_fill_if bus ();

    cache_line_fill dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // External data RAM: one-cycle read latency, stores {tag, line}.
    logic [147:0] ram_mem [256] = '{default: '0};
    always @(posedge clk) begin
        if (bus.ram_read_do)  bus.ram_q <= ram_mem[bus.ram_address[11:4]];
        if (bus.ram_write_do) ram_mem[bus.ram_address[11:4]] <= {bus.ram_address[31:12], bus.ram_data};
    end

    // Reference model of cache contents.
    bit           model_valid [256];
    logic [19:0]  model_tag   [256];
    logic [127:0] model_line  [256];

    function automatic int start_of(input logic [31:0] a);
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
        return int'(a[3:2]);
`else
        return 0;
`endif
    endfunction

    function automatic logic [31:0] exp_mem_addr(input logic [31:0] a);
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
        return {a[31:2], 2'b00};
`else
        return {a[31:4], 4'b0000};
`endif
    endfunction

    // Beat k of the burst lands in word (start + k) mod 4.
    function automatic logic [127:0] assemble(input logic [127:0] beats, input int start);
        logic [127:0] line;
        int w;
        line = '0;
        for (int k = 0; k < 4; k++) begin
            w = (start + k) % 4;
            line[w*32 +: 32] = beats[k*32 +: 32];
        end
        return line;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model_valid[i] = 1'b0;
    endtask

    task automatic check(input string name, input logic [147:0] act, input logic [147:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every req_done pulse must return the next expected line.
    logic [127:0] exp_q[$];
    always @(negedge clk) begin
        logic [127:0] e;
        #2;
        if (!rst && bus.req_done === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_done: got req_data %h, expected no completion", bus.req_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.req_data !== e) begin
                    n_err++;
                    $display("FAIL sb_req_data: got %h, expected %h", bus.req_data, e);
                end
            end
        end
    end

    task automatic do_req(input logic [31:0] addr, input logic [127:0] beats, input bit inval_wr,
                          input bit exp_hit, input logic [127:0] exp_line);
        int beat;
        int cyc;
        int idx;
        idx = int'(addr[11:4]);
        exp_q.push_back(exp_line);
        @(negedge clk);
        bus.mem_read_done  = 1'b0;
        bus.invalidate_all = 1'b0;
        bus.req_do         = 1'b1;
        bus.req_address    = addr;
        #1;
        check("idle_mem_read_do", 148'(bus.mem_read_do), 148'(0));
        check("accept_ram_read_do", 148'(bus.ram_read_do), 148'(1));
        check("accept_ram_address", 148'(bus.ram_address), 148'(addr));
        @(negedge clk);
        #1;
        check("lookup_req_done", 148'(bus.req_done), 148'(exp_hit));
        check("lookup_mem_read_do", 148'(bus.mem_read_do), 148'(0));
        check("lookup_ram_strobes", 148'({bus.ram_read_do, bus.ram_write_do}), 148'(0));
        if (exp_hit) begin
            bus.req_do = 1'b0;
            return;
        end
        beat = 0;
        cyc  = 0;
        while (beat < 4 && cyc < 64) begin
            @(negedge clk);
            bus.mem_read_done = 1'b0;
            #1;
            check("fill_mem_read_do", 148'(bus.mem_read_do), 148'(1));
            check("fill_mem_address", 148'(bus.mem_address), 148'(exp_mem_addr(addr)));
            if ($urandom_range(0, 2) != 0) begin
                bus.mem_read_done = 1'b1;
                bus.mem_read_data = beats[beat*32 +: 32];
                beat++;
            end
            cyc++;
        end
        @(negedge clk);
        bus.mem_read_done  = 1'b0;
        bus.invalidate_all = inval_wr;
        #1;
        check("write_mem_read_do", 148'(bus.mem_read_do), 148'(0));
        check("write_strobes", 148'({bus.ram_read_do, bus.ram_write_do}), 148'(2'b01));
        check("write_ram_address", 148'(bus.ram_address), 148'(addr));
        check("write_ram_data", 148'(bus.ram_data), 148'(exp_line));
        check("write_req_done", 148'(bus.req_done), 148'(1));
        bus.req_do = 1'b0;
        if (inval_wr) begin
            model_clear();
        end else begin
            model_valid[idx] = 1'b1;
            model_tag[idx]   = addr[31:12];
            model_line[idx]  = exp_line;
        end
    endtask

    task automatic do_req_model(input logic [31:0] addr, input bit inval_wr);
        logic [127:0] beats;
        int idx;
        bit hit;
        beats = {$urandom, $urandom, $urandom, $urandom};
        idx   = int'(addr[11:4]);
        hit   = model_valid[idx] && (model_tag[idx] == addr[31:12]);
        do_req(addr, beats, inval_wr, hit, hit ? model_line[idx] : assemble(beats, start_of(addr)));
    endtask

    // Reset pulse in the middle of a fill, after two beats were accepted.
    task automatic reset_mid_fill(input logic [31:0] addr);
        @(negedge clk);
        bus.mem_read_done  = 1'b0;
        bus.invalidate_all = 1'b0;
        bus.req_do         = 1'b1;
        bus.req_address    = addr;
        @(negedge clk);
        #1;
        check("rmf_lookup_req_done", 148'(bus.req_done), 148'(0));
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.mem_read_done = 1'b1;
            bus.mem_read_data = 32'hDEAD_0000 + 32'(k);
        end
        @(negedge clk);
        bus.mem_read_done = 1'b0;
        #1;
        check("rmf_mem_read_do_before", 148'(bus.mem_read_do), 148'(1));
        rst = 1'b1;
        #1;
        check("rmf_mem_read_do_async", 148'(bus.mem_read_do), 148'(0));
        check("rmf_outputs_in_reset", 148'({bus.req_done, bus.ram_read_do, bus.ram_write_do}), 148'(0));
        bus.req_do = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            check("rmf_no_write", 148'(bus.ram_write_do), 148'(0));
        end
        rst = 1'b0;
        model_clear();
    endtask

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] beats;
        bit           inval_wr;
        bit           exp_hit;
        logic [127:0] exp_line;
    } vec_t;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    localparam logic [127:0] LINE_0408 = 128'h0000000B_0000000A_0000000D_0000000C;
`else
    localparam logic [127:0] LINE_0408 = 128'h0000000D_0000000C_0000000B_0000000A;
`endif

    vec_t vecs[8];

    initial begin
        logic [31:0] a;
        vecs[0] = '{32'h0000_1230, 128'h00000044_00000033_00000022_00000011, 1'b0, 1'b0,
                    128'h00000044_00000033_00000022_00000011};
        vecs[1] = '{32'h0000_1230, 128'h0, 1'b0, 1'b1,
                    128'h00000044_00000033_00000022_00000011};
        vecs[2] = '{32'h0000_2230, 128'h00000088_00000077_00000066_00000055, 1'b0, 1'b0,
                    128'h00000088_00000077_00000066_00000055};
        vecs[3] = '{32'h0000_223C, 128'h0, 1'b0, 1'b1,
                    128'h00000088_00000077_00000066_00000055};
        vecs[4] = '{32'h0000_1230, 128'h000000D4_000000C3_000000B2_000000A1, 1'b0, 1'b0,
                    128'h000000D4_000000C3_000000B2_000000A1};
        vecs[5] = '{32'h0000_0408, 128'h0000000D_0000000C_0000000B_0000000A, 1'b0, 1'b0, LINE_0408};
        vecs[6] = '{32'h0000_0400, 128'h0, 1'b0, 1'b1, LINE_0408};
        vecs[7] = '{32'h0000_1230, 128'h0, 1'b0, 1'b1,
                    128'h000000D4_000000C3_000000B2_000000A1};

        // Clock/reset block; req_do is high during reset to prove the read strobe stays low.
        rst                = 1'b1;
        bus.req_do         = 1'b1;
        bus.req_address    = 32'h0000_1230;
        bus.invalidate_all = 1'b0;
        bus.mem_read_done  = 1'b0;
        bus.mem_read_data  = '0;
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        check("reset_strobes", 148'({bus.req_done, bus.ram_read_do, bus.ram_write_do, bus.mem_read_do}), 148'(0));
        check("reset_req_data", 148'(bus.req_data), 148'(0));
        check("reset_ram_data", 148'(bus.ram_data), 148'(0));
        check("reset_mem_address", 148'(bus.mem_address), 148'(0));
        bus.req_do = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_req(vecs[i].addr, vecs[i].beats, vecs[i].inval_wr, vecs[i].exp_hit, vecs[i].exp_line);
        end

        // Invalidate coincident with WRITE: data returned, line not retained.
        do_req_model(32'h0000_5670, 1'b1);
        do_req_model(32'h0000_5670, 1'b0);
        do_req_model(32'h0000_1230, 1'b0);

        // Aborted fill must leave the line invalid.
        reset_mid_fill(32'h0000_7770);
        do_req_model(32'h0000_7770, 1'b0);
        do_req_model(32'h0000_7774, 1'b0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk);
                bus.mem_read_done = 1'b1;
                bus.mem_read_data = $urandom;
            end
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk);
                bus.invalidate_all = 1'b1;
                model_clear();
            end
            a = {12'h000, 8'($urandom_range(0, 3)), 8'($urandom_range(8'h20, 8'h27)), 4'($urandom_range(0, 15))};
            do_req_model(a, $urandom_range(0, 9) == 0);
        end

        @(negedge clk);
        bus.mem_read_done  = 1'b0;
        bus.invalidate_all = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        check("sb_all_done", 148'(exp_q.size()), 148'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cache_line_fill.md
CACHE_LINE_FILL -- requirements
Module: cache_line_fill

Interface
- REQ-001: Parameters: none; line = 128 bits, 256 sets indexed by address[11:4], tag = address[31:12].
- REQ-002: clk  input  1  sole clock, all state on rising edge.
- REQ-003: rst  input  1  reset, asynchronous, active-high.
- REQ-004: req_do  input  1  read request, held with req_address stable until req_done.
- REQ-005: req_address  input  32  requested byte address.
- REQ-006: req_done  output  1  one-cycle pulse, req_data valid.
- REQ-007: req_data  output  128  returned line.
- REQ-008: invalidate_all  input  1  clear every valid bit.
- REQ-009: ram_address  output  32  address to data RAM; bits [31:12] are the tag written.
- REQ-010: ram_read_do  output  1  data RAM read strobe.
- REQ-011: ram_q  input  148  {tag[19:0], line[127:0]}, valid one cycle after ram_read_do.
- REQ-012: ram_write_do  output  1  data RAM write strobe.
- REQ-013: ram_data  output  128  line written to data RAM.
- REQ-014: mem_read_do  output  1  burst read request to memory, level.
- REQ-015: mem_address  output  32  burst start address, bits [1:0] = 0.
- REQ-016: mem_read_done  input  1  one 32-bit beat valid this cycle.
- REQ-017: mem_read_data  input  32  beat data.

Function
- REQ-018: States IDLE, LOOKUP, FILL, WRITE; one request at a time.
- REQ-019: IDLE: req_do=1 -> ram_read_do=1 and ram_address=req_address same cycle, latch address, -> LOOKUP.
- REQ-020: LOOKUP: hit = valid[index] & (ram_q[147:128] == latched tag) & !invalidate_all.
- REQ-021: Hit -> req_done=1, req_data=ram_q[127:0] in LOOKUP cycle, -> IDLE; hit latency = 1 cycle after accept.
- REQ-022: Miss -> FILL; beat counter cleared; mem_read_do rises next cycle.
- REQ-023: FILL: mem_read_do=1 continuously until 4th mem_read_done accepted, deasserted the following cycle.
- REQ-024: Beat k (k=0..3) lands in line word ((start_word + k) mod 4); 2-bit counter wraps, start_word per REQ-031.
- REQ-025: mem_read_done outside FILL is ignored.
- REQ-026: After 4th beat -> WRITE: ram_write_do=1, ram_address=latched address, ram_data=assembled line, req_done=1, req_data=assembled line, valid[index] set, -> IDLE.
- REQ-027: invalidate_all clears all 256 valid bits next edge in any state; coincident with WRITE, invalidate wins (valid stays 0), data still returned.
- REQ-028: ram_read_do and ram_write_do never both 1; both 0 outside IDLE-accept and WRITE.
- REQ-029: req_do sampled only in IDLE; new request accepted earliest cycle after req_done.

Reset
- REQ-030: rst=1: state IDLE, all valid bits 0, counter 0, partial line discarded; outputs req_done, ram_read_do, ram_write_do, mem_read_do = 0; req_data, ram_data, mem_address = 0; mid-fill reset drops mem_read_do asynchronously.

Configuration
- REQ-031: CACHE_CRITICAL_WORD_FIRST_EN defined: mem_address = {addr[31:4], addr[3:2], 2'b00}, start_word = addr[3:2]; undefined: mem_address = {addr[31:4], 4'b0}, start_word = 0.

Verification
- REQ-032: After reset, req 0x0000_1230 -> LOOKUP miss, mem_read_do, beats 0x11,0x22,0x33,0x44 -> ram_write_do with ram_data 0x44_33_22_11 (word3..0), req_done same cycle.
- REQ-033: Repeat 0x0000_1230 -> req_done 1 cycle after accept, no mem_read_do, data equal to ram_q[127:0].
- REQ-034: Req 0x0000_2230 (same index 0x23, tag 0x00002) -> miss, refill, valid remains 1 for index 0x23.
- REQ-035: With CACHE_CRITICAL_WORD_FIRST_EN, req 0x0000_0408 -> mem_address 0x0000_0408, beats A,B,C,D stored at words 2,3,0,1.
- REQ-036: rst pulse after 2nd beat -> mem_read_do 0 immediately, next request to same line misses, no ram_write_do from aborted fill.
- REQ-037: invalidate_all in WRITE cycle -> req_done=1 with line, following request to same line misses.
